// File: rtl/mult_seq_engine.sv
// mult_seq_engine: sequential radix-2 shift-add multiplier.
//
// One multiplier bit is consumed per clock. Start_i is accepted in IDLE or
// DONE. Done_o pulses DATA_WIDTH+1 cycles after the accepting edge, whatever
// the operand values.
//
// Optional feature: define MULT_SIGNED_EN to add the Signed_i port and
// two's-complement support (operands become magnitudes, the product is
// negated when the operand signs differ). Without it, all operations are
// unsigned and Signed_i does not exist.
//
// Handshake: Start_i is a level request. It is accepted on any rising edge
// where the engine is not in RUN and WB_RST is low. A Start_i seen in RUN is
// dropped, and Drop_o pulses for that cycle. Start_i has no effect during reset.
//
// Ports:
//   WB_CLK    in   clock; all logic is on its rising edge
//   WB_RST    in   synchronous active-high reset
//   Start_i   in   multiply request
//   A_i       in   multiplicand, sampled on acceptance
//   B_i       in   multiplier, sampled on acceptance
//   Signed_i  in   two's-complement select (MULT_SIGNED_EN builds only)
//   Busy_o    out  high while iterating (state == RUN)
//   Done_o    out  one-cycle pulse when C_o takes a new product
//   Valid_o   out  sticky result-valid flag
//   Drop_o    out  one-cycle pulse when Start_i is ignored
//   C_o       out  2*DATA_WIDTH product, held until the next Done_o
//   state_dbg out  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module mult_seq_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                    WB_CLK,
    input  logic                    WB_RST,
    input  logic                    Start_i,
    input  logic [DATA_WIDTH-1:0]   A_i,
    input  logic [DATA_WIDTH-1:0]   B_i,
`ifdef MULT_SIGNED_EN
    input  logic                    Signed_i,
`endif
    output logic                    Busy_o,
    output logic                    Done_o,
    output logic                    Valid_o,
    output logic                    Drop_o,
    output logic [2*DATA_WIDTH-1:0] C_o,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH:0]     acc;     // extra top bit catches the add carry
    logic [DATA_WIDTH-1:0]   mq;      // multiplier; product low half shifts in
    logic [DATA_WIDTH-1:0]   mcand;
    logic [CNT_WIDTH-1:0]    cnt;

    logic [DATA_WIDTH-1:0]   a_mag;
    logic [DATA_WIDTH-1:0]   b_mag;
    logic [DATA_WIDTH:0]     sum;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [2*DATA_WIDTH-1:0] result;

`ifdef MULT_SIGNED_EN
    logic neg;  // operand signs differed; negate on completion
    logic a_neg;
    logic b_neg;

    always_comb begin
        a_neg  = Signed_i & A_i[DATA_WIDTH-1];
        b_neg  = Signed_i & B_i[DATA_WIDTH-1];
        // The most negative value maps to itself, which is its correct
        // unsigned magnitude.
        a_mag  = a_neg ? (~A_i + 1'b1) : A_i;
        b_mag  = b_neg ? (~B_i + 1'b1) : B_i;
        prod   = {acc[DATA_WIDTH-1:0], mq};
        result = neg ? (~prod + 1'b1) : prod;
    end
`else
    always_comb begin
        a_mag  = A_i;
        b_mag  = B_i;
        prod   = {acc[DATA_WIDTH-1:0], mq};
        result = prod;
    end
`endif

    // acc[DATA_WIDTH] is always 0 here because the previous shift cleared it.
    // The add therefore never loses its carry.
    always_comb begin
        sum = acc + {1'b0, (mq[0] ? mcand : {DATA_WIDTH{1'b0}})};
    end

    assign state_dbg = state;

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state   <= IDLE;
            acc     <= '0;
            mq      <= '0;
            mcand   <= '0;
            cnt     <= '0;
            C_o     <= '0;
            Busy_o  <= 1'b0;
            Done_o  <= 1'b0;
            Valid_o <= 1'b0;
            Drop_o  <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            Done_o <= 1'b0;
            Drop_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start_i) begin
                        mcand   <= a_mag;
                        mq      <= b_mag;
                        acc     <= '0;
                        cnt     <= CNT_WIDTH'(DATA_WIDTH);
                        Valid_o <= 1'b0;
                        Busy_o  <= 1'b1;
                        state   <= RUN;
`ifdef MULT_SIGNED_EN
                        neg     <= a_neg ^ b_neg;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (Start_i) begin
                        Drop_o <= 1'b1;
                    end
                    if (cnt != '0) begin
                        // Shift the {acc, mq} pair right by one bit.
                        // The sum's LSB becomes the next product bit.
                        acc <= {1'b0, sum[DATA_WIDTH:1]};
                        mq  <= {sum[0], mq[DATA_WIDTH-1:1]};
                        cnt <= cnt - CNT_WIDTH'(1);
                    end else begin
                        // The counter hit zero on the previous edge. This extra
                        // cycle gives a fixed DATA_WIDTH+1 latency.
                        C_o     <= result;
                        Done_o  <= 1'b1;
                        Valid_o <= 1'b1;
                        Busy_o  <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_engine.sv
// Directed self-checking bench for mult_seq_engine (default 32-bit build).
// Expected products are hand-computed constants.
module tb_mult_seq_engine;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef MULT_SIGNED_EN
    logic         sgn;
`endif
    logic         busy;
    logic         done;
    logic         valid;
    logic         drop;
    logic [2*W-1:0] c;
    logic [1:0]   state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mult_seq_engine #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .WB_CLK   (clk),
        .WB_RST   (rst),
        .Start_i  (start),
        .A_i      (a),
        .B_i      (b),
`ifdef MULT_SIGNED_EN
        .Signed_i (sgn),
`endif
        .Busy_o   (busy),
        .Done_o   (done),
        .Valid_o  (valid),
        .Drop_o   (drop),
        .C_o      (c),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse Start_i for one edge. The cycle number of the accepting edge is
    // returned.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            output int acc_cyc);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        acc_cyc = cyc;
        start = 1'b0;
    endtask

    // Poll for Done_o within a bounded number of cycles. -1 means it timed out.
    task automatic wait_done(output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    // Count Done_o pulses over n cycles.
    task automatic count_done(input int n, output int cnt_out);
        cnt_out = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) cnt_out++;
        end
    endtask

    // Run one full multiply and check its latency and product.
    task automatic run_check(input string tag, input logic [W-1:0] av,
                             input logic [W-1:0] bv, input logic [63:0] exp);
        int t0;
        int t1;
        start_op(av, bv, t0);
        wait_done(t1);
        check_val({tag, "_lat"}, 64'(t1 - t0), 64'(LAT));
        check_val({tag, "_c"}, c, exp);
    endtask

    int t0;
    int t1;
    int t2;
    int nd;

    initial begin
        rst   = 1'b1;
        start = 1'b1;          // a Start during reset must be ignored
        a     = '1;
        b     = '1;
`ifdef MULT_SIGNED_EN
        sgn   = 1'b0;
`endif
        tick();
        tick();
        check_val("rst_drop_held", {63'd0, drop}, 64'd0);
        start = 1'b0;
        tick();
        rst = 1'b0;
        check_val("rst_c", c, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_valid", {63'd0, valid}, 64'd0);
        check_val("rst_drop", {63'd0, drop}, 64'd0);
        check_val("rst_state", {62'd0, state_dbg}, 64'd0);

        // Maximum operands.
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
        check_val("max_busy", {63'd0, busy}, 64'd1);
        check_val("max_state", {62'd0, state_dbg}, 64'd1);
        wait_done(t1);
        check_val("max_lat", 64'(t1 - t0), 64'(LAT));
        check_val("max_c", c, 64'hFFFF_FFFE_0000_0001);
        check_val("max_valid", {63'd0, valid}, 64'd1);
        check_val("max_busy_off", {63'd0, busy}, 64'd0);
        tick();
        check_val("max_done_pulse", {63'd0, done}, 64'd0);
        check_val("max_c_held", c, 64'hFFFF_FFFE_0000_0001);
        check_val("max_state_idle", {62'd0, state_dbg}, 64'd0);

        run_check("zero", 32'd0, 32'h1234_5678, 64'd0);
        run_check("three_five", 32'd3, 32'd5, 64'd15);
        run_check("mixed", 32'h0001_0003, 32'h0000_0100, 64'h0000_0000_0100_0300);

        // Start during RUN is dropped; later operand changes do not matter.
        start_op(32'd7, 32'd9, t0);
        check_val("drop_valid_clr", {63'd0, valid}, 64'd0);
        repeat (10) tick();
        a     = 32'd100;
        b     = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("drop_pulse", {63'd0, drop}, 64'd1);
        tick();
        check_val("drop_pulse_end", {63'd0, drop}, 64'd0);
        wait_done(t1);
        check_val("drop_lat", 64'(t1 - t0), 64'(LAT));
        check_val("drop_c", c, 64'd63);
        count_done(45, nd);
        check_val("drop_extra_done", 64'(nd), 64'd0);

        // Back-to-back: Start held through the DONE cycle.
        start_op(32'd2, 32'd3, t0);
        wait_done(t1);
        check_val("b2b_first_c", c, 64'd6);
        a     = 32'd4;
        b     = 32'd5;
        start = 1'b1;
        tick();                 // accepting edge, sampled in DONE
        t0    = cyc;
        start = 1'b0;
        check_val("b2b_state_run", {62'd0, state_dbg}, 64'd1);
        check_val("b2b_valid_clr", {63'd0, valid}, 64'd0);
        check_val("b2b_c_kept", c, 64'd6);
        wait_done(t2);
        check_val("b2b_lat", 64'(t2 - t0), 64'(LAT));
        // The DONE cycle plus a full operation separates the two Done_o pulses.
        check_val("b2b_spacing", 64'(t2 - t1), 64'(LAT + 1));
        check_val("b2b_second_c", c, 64'd20);

        // Reset in the middle of RUN aborts the operation.
        start_op(32'd6, 32'd7, t0);
        repeat (20) tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_val("mid_rst_busy", {63'd0, busy}, 64'd0);
        check_val("mid_rst_c", c, 64'd0);
        check_val("mid_rst_valid", {63'd0, valid}, 64'd0);
        check_val("mid_rst_drop", {63'd0, drop}, 64'd0);
        check_val("mid_rst_state", {62'd0, state_dbg}, 64'd0);
        count_done(45, nd);
        check_val("mid_rst_no_done", 64'(nd), 64'd0);
        run_check("after_rst", 32'd11, 32'd13, 64'd143);

`ifdef MULT_SIGNED_EN
        sgn = 1'b1;
        run_check("s_neg2x3", 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        run_check("s_min_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_check("s_negneg", 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'd15);
        sgn = 1'b0;
        run_check("u_fffe_x3", 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
